// File: rtl/adc_input_common_pkg.sv
// rtl/adc_input_common_pkg.sv - shared register offsets, bit masks and write-FSM state type for adc_input
package adc_input_common_pkg;

    // Register offsets within the AXI4-Lite window
    localparam logic [31:0] AXI_ADDR_CR    = 32'h0000_0000;
    localparam logic [31:0] AXI_ADDR_SR    = 32'h0000_0004;
    localparam logic [31:0] AXI_ADDR_DSIZE = 32'h0000_0008;

    // CR / SR bit masks; all live in byte lane 0
    localparam logic [31:0] _CR_TEST  = 32'h0000_0001;
    localparam logic [31:0] _CR_START = 32'h0000_0002;
    localparam logic [31:0] _SR_PC    = 32'h0000_0001;

    // Write-channel FSM states
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_W,
        S_WAIT_AW,
        S_COMMIT,
        S_RESP
    } wr_state_e;

endpackage

// File: rtl/adc_input_axi_write.sv
// rtl/adc_input_axi_write.sv - AXI4-Lite write slave owning adc_input control registers
module adc_input_axi_write
    import adc_input_common_pkg::*;
#(
    parameter logic [31:0] DSIZE_RESET = 32'h0000_0000,
    parameter int          ADDR_LSBS   = 8
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic [31:0] AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    input  logic        busy,
    output logic        cr_test,
    output logic        cr_start,
    output logic        sr_pc_clr,
    output logic [31:0] dsize
);

    // Only the low ADDR_LSBS address bits take part in decode; upper bits alias
    localparam logic [31:0] ADDR_MASK = (ADDR_LSBS >= 32) ? 32'hFFFF_FFFF
                                        : ((32'h1 << ADDR_LSBS) - 32'h1);

    wr_state_e   state_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [3:0]  strb_q;
    logic        cr_test_q;
    logic        cr_start_q;
    logic        sr_pc_clr_q;
    logic [31:0] dsize_q;

    logic        sel_cr;
    logic        sel_sr;
    logic        sel_dsize;
    logic        cr_test_d;
    logic        cr_start_d;
    logic        sr_pc_clr_d;
    logic [31:0] dsize_d;

    // Decode the held address/data into the register values applied at commit
    always_comb begin
        sel_cr      = (addr_q & ADDR_MASK) == AXI_ADDR_CR;
        sel_sr      = (addr_q & ADDR_MASK) == AXI_ADDR_SR;
        sel_dsize   = (addr_q & ADDR_MASK) == AXI_ADDR_DSIZE;
        cr_test_d   = cr_test_q;
        cr_start_d  = 1'b0;
        sr_pc_clr_d = 1'b0;
        dsize_d     = dsize_q;
        if (sel_cr && strb_q[0]) begin
            cr_test_d  = (data_q & _CR_TEST) != 32'h0;
            cr_start_d = ((data_q & _CR_START) != 32'h0) && !busy;
        end
        if (sel_sr && strb_q[0]) begin
            sr_pc_clr_d = (data_q & _SR_PC) != 32'h0;
        end
        if (sel_dsize && !busy) begin
            for (int k = 0; k < 4; k++) begin
                if (strb_q[k]) begin
                    dsize_d[8*k +: 8] = data_q[8*k +: 8];
                end
            end
        end
    end

    // Write FSM: collect AW and W in any order, commit once, then hold B until accepted
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= S_IDLE;
            addr_q      <= 32'h0;
            data_q      <= 32'h0;
            strb_q      <= 4'h0;
            cr_test_q   <= 1'b0;
            cr_start_q  <= 1'b0;
            sr_pc_clr_q <= 1'b0;
            dsize_q     <= DSIZE_RESET;
        end else begin
            // Pulses live for exactly the first S_RESP cycle
            cr_start_q  <= 1'b0;
            sr_pc_clr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (AWVALID && WVALID) begin
                        addr_q  <= AWADDR;
                        data_q  <= WDATA;
                        strb_q  <= WSTRB;
                        state_q <= S_COMMIT;
                    end else if (AWVALID) begin
                        addr_q  <= AWADDR;
                        state_q <= S_WAIT_W;
                    end else if (WVALID) begin
                        data_q  <= WDATA;
                        strb_q  <= WSTRB;
                        state_q <= S_WAIT_AW;
                    end
                end
                S_WAIT_W: begin
                    if (WVALID) begin
                        data_q  <= WDATA;
                        strb_q  <= WSTRB;
                        state_q <= S_COMMIT;
                    end
                end
                S_WAIT_AW: begin
                    if (AWVALID) begin
                        addr_q  <= AWADDR;
                        state_q <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    cr_test_q   <= cr_test_d;
                    cr_start_q  <= cr_start_d;
                    sr_pc_clr_q <= sr_pc_clr_d;
                    dsize_q     <= dsize_d;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (BREADY) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign AWREADY   = (state_q == S_IDLE) || (state_q == S_WAIT_AW);
    assign WREADY    = (state_q == S_IDLE) || (state_q == S_WAIT_W);
    assign BVALID    = (state_q == S_RESP);
    assign BRESP     = 2'b00;
    assign cr_test   = cr_test_q;
    assign cr_start  = cr_start_q;
    assign sr_pc_clr = sr_pc_clr_q;
    assign dsize     = dsize_q;

endmodule

// File: tb/tb_adc_input_axi_write.sv
// tb/tb_adc_input_axi_write.sv - scoreboard testbench for adc_input_axi_write
module tb_adc_input_axi_write;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic        busy;
    logic        cr_test;
    logic        cr_start;
    logic        sr_pc_clr;
    logic [31:0] dsize;

    adc_input_axi_write dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .AWADDR    (AWADDR),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .WDATA     (WDATA),
        .WSTRB     (WSTRB),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .BRESP     (BRESP),
        .BVALID    (BVALID),
        .BREADY    (BREADY),
        .busy      (busy),
        .cr_test   (cr_test),
        .cr_start  (cr_start),
        .sr_pc_clr (sr_pc_clr),
        .dsize     (dsize)
    );

    always #5 ACLK = ~ACLK;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        cr_test;
        logic [31:0] dsize;
        logic        cr_start;
        logic        sr_pc_clr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic        m_cr_test = 1'b0;
    logic [31:0] m_dsize   = 32'h0;
    logic        prev_bv   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: register file semantics applied per complete write
    task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input logic bsy);
        exp_t e;
        logic [7:0] off;
        off         = addr[7:0];
        e.cr_start  = 1'b0;
        e.sr_pc_clr = 1'b0;
        if (off == 8'h00 && strb[0]) begin
            m_cr_test  = data[0];
            e.cr_start = data[1] & ~bsy;
        end
        if (off == 8'h04 && strb[0]) begin
            e.sr_pc_clr = data[0];
        end
        if (off == 8'h08 && !bsy) begin
            for (int k = 0; k < 4; k++) begin
                if (strb[k]) m_dsize[8*k +: 8] = data[8*k +: 8];
            end
        end
        e.cr_test = m_cr_test;
        e.dsize   = m_dsize;
        exp_q.push_back(e);
    endtask

    task automatic do_aw(input logic [31:0] addr, input int dly, output bit ok);
        bit hs;
        ok = 1'b0;
        repeat (dly) @(posedge ACLK);
        #1;
        AWADDR  = addr;
        AWVALID = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            hs = AWREADY;
            @(posedge ACLK);
            if (hs) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        AWVALID = 1'b0;
        if (!ok) check("aw_handshake_timeout", 0, 1);
    endtask

    task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input int dly, output bit ok);
        bit hs;
        ok = 1'b0;
        repeat (dly) @(posedge ACLK);
        #1;
        WDATA  = data;
        WSTRB  = strb;
        WVALID = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            hs = WREADY;
            @(posedge ACLK);
            if (hs) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        WVALID = 1'b0;
        if (!ok) check("w_handshake_timeout", 0, 1);
    endtask

    // One full write: AW/W with independent delays, latency check, B with BREADY stall
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic bsy, input int da, input int dw, input int bd);
        bit ok_a, ok_w;
        busy = bsy;
        model_write(addr, data, strb, bsy);
        fork
            do_aw(addr, da, ok_a);
            do_w(data, strb, dw, ok_w);
        join
        check("bvalid_before_commit", BVALID, 0);
        @(posedge ACLK);
        #1;
        check("bvalid_latency", BVALID, 1);
        BREADY = 1'b0;
        repeat (bd) begin
            @(negedge ACLK);
            check("bvalid_hold", BVALID, 1);
            check("bresp_hold", BRESP, 2'b00);
        end
        @(negedge ACLK);
        BREADY = 1'b1;
        @(posedge ACLK);
        #1;
        BREADY = 1'b0;
        busy   = 1'b0;
        check("bvalid_after_b", BVALID, 0);
    endtask

    // Monitor: pop the scoreboard whenever a response first appears
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            prev_bv <= 1'b0;
        end else begin
            if (BVALID && !prev_bv) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_bvalid", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("cr_test", cr_test, mon_e.cr_test);
                    check("dsize", dsize, mon_e.dsize);
                    check("cr_start_pulse", cr_start, mon_e.cr_start);
                    check("sr_pc_clr_pulse", sr_pc_clr, mon_e.sr_pc_clr);
                end
            end else begin
                check("cr_start_quiet", cr_start, 0);
                check("sr_pc_clr_quiet", sr_pc_clr, 0);
            end
            if (BVALID) begin
                check("bresp_okay", BRESP, 2'b00);
                check("awready_in_resp", AWREADY, 0);
                check("wready_in_resp", WREADY, 0);
            end
            prev_bv <= BVALID;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        logic [31:0] r;
        logic [7:0]  off;
        ARESETN = 1'b0;
        AWADDR  = 32'h0;
        AWVALID = 1'b0;
        WDATA   = 32'h0;
        WSTRB   = 4'h0;
        WVALID  = 1'b0;
        BREADY  = 1'b0;
        busy    = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        check("rst_bvalid", BVALID, 0);
        check("rst_bresp", BRESP, 2'b00);
        check("rst_cr_test", cr_test, 0);
        check("rst_cr_start", cr_start, 0);
        check("rst_sr_pc_clr", sr_pc_clr, 0);
        check("rst_dsize", dsize, 32'h0);
        ARESETN = 1'b1;
        @(posedge ACLK);
        #1;

        axi_write(32'h08, 32'h0000_1000, 4'hF, 1'b0, 0, 0, 0);
        axi_write(32'h00, 32'h0000_0003, 4'hF, 1'b0, 0, 3, 0);
        axi_write(32'h08, 32'h0000_0000, 4'hF, 1'b0, 0, 0, 0);
        axi_write(32'h08, 32'hAABB_CCDD, 4'b0101, 1'b0, 3, 0, 0);
        check("dsize_strobe_direct", dsize, 32'h00BB_00DD);
        axi_write(32'h0C, 32'h1234_5678, 4'hF, 1'b0, 0, 0, 5);
        axi_write(32'h08, 32'h0000_0055, 4'hF, 1'b1, 0, 0, 0);
        axi_write(32'h00, 32'h0000_0002, 4'hF, 1'b1, 0, 0, 0);
        axi_write(32'h04, 32'h0000_0001, 4'hF, 1'b0, 1, 0, 1);
        axi_write(32'h00, 32'h0000_0003, 4'h0, 1'b0, 0, 0, 0);
        axi_write(32'h08, 32'hFFFF_FFFF, 4'h0, 1'b0, 2, 1, 0);
        axi_write(32'hFFFF_FF08, 32'h0000_0777, 4'hF, 1'b0, 0, 0, 0);

        // Reset while the address is held and data has not arrived
        do_aw(32'h08, 0, ok);
        #2;
        ARESETN = 1'b0;
        #1;
        check("midrst_bvalid", BVALID, 0);
        check("midrst_dsize", dsize, 32'h0);
        check("midrst_cr_test", cr_test, 0);
        check("midrst_cr_start", cr_start, 0);
        check("midrst_sr_pc_clr", sr_pc_clr, 0);
        m_cr_test = 1'b0;
        m_dsize   = 32'h0;
        exp_q.delete();
        @(posedge ACLK);
        @(posedge ACLK);
        #3;
        ARESETN = 1'b1;
        @(posedge ACLK);
        #1;
        check("postrst_dsize", dsize, 32'h0);
        axi_write(32'h08, 32'hCAFE_0001, 4'hF, 1'b0, 1, 0, 0);

        for (int n = 0; n < 80; n++) begin
            r = $urandom();
            case ($urandom_range(0, 4))
                0:       off = 8'h00;
                1:       off = 8'h04;
                2:       off = 8'h08;
                3:       off = 8'h0C;
                default: off = 8'($urandom_range(0, 255));
            endcase
            axi_write({r[31:8], off}, $urandom(), 4'($urandom_range(0, 15)),
                      ($urandom_range(0, 3) == 0), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end

        repeat (3) @(posedge ACLK);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
